// File: rtl/ddr_io_pattern_gen.sv
// Burst-framed DDR I/O stress pattern generator with a delayed-reference loopback checker.
// Drives registered D0/D1/DQS/OE words for ODDRX1F/BB and checks IDDR return data.
module ddr_io_pattern_gen #(
  parameter int DQ_WIDTH      = 16,
  parameter int BURST_LEN     = 8,
  parameter int GAP_LEN       = 4,
  parameter int CHK_LATENCY   = 2,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     SYS_CLK,
  input  logic                     RST,
  input  logic                     PLL_LOCKED,
  input  logic                     ENABLE,
  input  logic [1:0]               MODE,
  input  logic                     CHK_EN,
  input  logic                     CLR_ERR,
  output logic [DQ_WIDTH-1:0]      DQ_D0,
  output logic [DQ_WIDTH-1:0]      DQ_D1,
  output logic                     DQS_D0,
  output logic                     DQS_D1,
  output logic                     OE,
  input  logic [DQ_WIDTH-1:0]      RX_D0,
  input  logic [DQ_WIDTH-1:0]      RX_D1,
  output logic                     BUSY,
  output logic [31:0]              BEAT_CNT,
  output logic [ERR_CNT_WIDTH-1:0] ERR_CNT,
  output logic                     ERR_FLAG,
  output logic [31:0]              FIRST_ERR_BEAT
);

  localparam int LMAX = (BURST_LEN > GAP_LEN) ? BURST_LEN : GAP_LEN;
  localparam int CW   = (LMAX > 1) ? $clog2(LMAX) : 1;
  localparam int KW   = $clog2(DQ_WIDTH);

  localparam logic [CW-1:0]       BURST_LAST = CW'(BURST_LEN - 1);
  localparam logic [CW-1:0]       GAP_LAST   = CW'(GAP_LEN - 1);
  localparam logic [KW-1:0]       WALK_LAST  = KW'(DQ_WIDTH - 2);
  localparam logic [DQ_WIDTH-1:0] ALT_D0     = {(DQ_WIDTH/2){2'b01}};
  localparam logic [DQ_WIDTH-1:0] ALT_D1     = {(DQ_WIDTH/2){2'b10}};

  typedef enum logic [1:0] {IDLE, PREAMBLE, BURST, GAP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   len_q, len_d;
  logic [1:0]      mode_q;
  logic            launch;

  logic [DQ_WIDTH-1:0] cnt_q;
  logic [KW-1:0]       walk_k, walk_nxt;
  logic [30:0]         lfsr_q;
  logic [DQ_WIDTH-1:0] pat_d0, pat_d1;

  logic [CHK_LATENCY-1:0]               vld_pipe;
  logic [CHK_LATENCY-1:0][DQ_WIDTH-1:0] exp_d0_pipe;
  logic [CHK_LATENCY-1:0][DQ_WIDTH-1:0] exp_d1_pipe;
  logic [CHK_LATENCY-1:0][31:0]         tag_pipe;
  logic                                 mismatch;

  // Next-state logic; a lost PLL lock overrides everything and parks in IDLE.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    case (state_q)
      IDLE:     if (ENABLE) state_d = PREAMBLE;
      PREAMBLE: begin
        state_d = BURST;
        len_d   = '0;
      end
      BURST: begin
        if (len_q == BURST_LAST) begin
          state_d = GAP;
          len_d   = '0;
        end else begin
          len_d = len_q + CW'(1);
        end
      end
      GAP: begin
        if (len_q == GAP_LAST) begin
          state_d = ENABLE ? PREAMBLE : IDLE;
          len_d   = '0;
        end else begin
          len_d = len_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (!PLL_LOCKED) begin
      state_d = IDLE;
      len_d   = '0;
    end
  end

  assign launch = (state_d == BURST);

  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      state_q <= IDLE;
      len_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      if (state_q == IDLE && state_d == PREAMBLE) mode_q <= MODE;
    end
  end

  // Pattern word for the beat being launched on this edge.
  always_comb begin
    pat_d0   = '0;
    pat_d1   = '0;
    walk_nxt = (walk_k >= WALK_LAST) ? '0 : walk_k + KW'(2);
    case (mode_q)
      2'd0: begin
        pat_d0 = cnt_q;
        pat_d1 = ~cnt_q;
      end
      2'd1: begin
        pat_d0 = DQ_WIDTH'(1) << walk_k;
        pat_d1 = DQ_WIDTH'(1) << (walk_k + KW'(1));
      end
      2'd2: begin
        pat_d0 = lfsr_q[DQ_WIDTH-1:0];
        pat_d1 = ~lfsr_q[DQ_WIDTH-1:0];
      end
      default: begin
        pat_d0 = ALT_D0;
        pat_d1 = ALT_D1;
      end
    endcase
  end

  // Only the active mode's generator steps, so each pattern resumes where it left off.
  always_ff @(posedge SYS_CLK) begin
    if (RST || !PLL_LOCKED) begin
      cnt_q  <= '0;
      walk_k <= '0;
      lfsr_q <= '1;
    end else if (launch) begin
      case (mode_q)
        2'd0:    cnt_q  <= cnt_q + DQ_WIDTH'(1);
        2'd1:    walk_k <= walk_nxt;
        2'd2:    lfsr_q <= {lfsr_q[29:0], lfsr_q[30] ^ lfsr_q[27]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      DQ_D0    <= '0;
      DQ_D1    <= '0;
      DQS_D0   <= 1'b0;
      DQS_D1   <= 1'b0;
      OE       <= 1'b0;
      BUSY     <= 1'b0;
      BEAT_CNT <= '0;
    end else begin
      DQ_D0  <= launch ? pat_d0 : '0;
      DQ_D1  <= launch ? pat_d1 : '0;
      DQS_D0 <= launch;
      DQS_D1 <= 1'b0;
      OE     <= (state_d == PREAMBLE) || launch;
      BUSY   <= (state_d != IDLE);
      if (launch) BEAT_CNT <= BEAT_CNT + 32'd1;
    end
  end

  // Reference pipeline: stage 0 loads alongside the output registers.
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      vld_pipe    <= '0;
      exp_d0_pipe <= '0;
      exp_d1_pipe <= '0;
      tag_pipe    <= '0;
    end else begin
      for (int i = CHK_LATENCY - 1; i > 0; i--) begin
        vld_pipe[i]    <= vld_pipe[i-1];
        exp_d0_pipe[i] <= exp_d0_pipe[i-1];
        exp_d1_pipe[i] <= exp_d1_pipe[i-1];
        tag_pipe[i]    <= tag_pipe[i-1];
      end
      vld_pipe[0]    <= launch;
      exp_d0_pipe[0] <= pat_d0;
      exp_d1_pipe[0] <= pat_d1;
      tag_pipe[0]    <= BEAT_CNT;
    end
  end

  assign mismatch = vld_pipe[CHK_LATENCY-1] & CHK_EN &
                    ((RX_D0 != exp_d0_pipe[CHK_LATENCY-1]) |
                     (RX_D1 != exp_d1_pipe[CHK_LATENCY-1]));

  // A clear coinciding with a mismatch restarts the accounting from that mismatch.
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      ERR_CNT        <= '0;
      ERR_FLAG       <= 1'b0;
      FIRST_ERR_BEAT <= '0;
    end else if (CLR_ERR) begin
      ERR_CNT        <= mismatch ? ERR_CNT_WIDTH'(1) : '0;
      ERR_FLAG       <= mismatch;
      FIRST_ERR_BEAT <= mismatch ? tag_pipe[CHK_LATENCY-1] : '0;
    end else if (mismatch) begin
      if (ERR_CNT != {ERR_CNT_WIDTH{1'b1}}) ERR_CNT <= ERR_CNT + ERR_CNT_WIDTH'(1);
      if (!ERR_FLAG) begin
        ERR_FLAG       <= 1'b1;
        FIRST_ERR_BEAT <= tag_pipe[CHK_LATENCY-1];
      end
    end
  end

endmodule

// File: tb/tb_ddr_io_pattern_gen.sv
// Directed + randomized bench for ddr_io_pattern_gen against a frame-position reference model.
module tb_ddr_io_pattern_gen;

  localparam int W   = 16;
  localparam int BL  = 8;
  localparam int GL  = 4;
  localparam int L   = 2;
  localparam int ECW = 4;
  localparam int NH  = 8192;

  logic           clk = 1'b0;
  logic           rst, pll, en, chk_en, clr;
  logic [1:0]     mode;
  logic [W-1:0]   dq_d0, dq_d1, rx_d0, rx_d1;
  logic           dqs_d0, dqs_d1, oe, busy, err_flag;
  logic [31:0]    beat_cnt, first_err_beat;
  logic [ECW-1:0] err_cnt;

  ddr_io_pattern_gen #(
    .DQ_WIDTH(W), .BURST_LEN(BL), .GAP_LEN(GL), .CHK_LATENCY(L), .ERR_CNT_WIDTH(ECW)
  ) dut (
    .SYS_CLK(clk), .RST(rst), .PLL_LOCKED(pll), .ENABLE(en), .MODE(mode),
    .CHK_EN(chk_en), .CLR_ERR(clr), .DQ_D0(dq_d0), .DQ_D1(dq_d1),
    .DQS_D0(dqs_d0), .DQS_D1(dqs_d1), .OE(oe), .RX_D0(rx_d0), .RX_D1(rx_d1),
    .BUSY(busy), .BEAT_CNT(beat_cnt), .ERR_CNT(err_cnt), .ERR_FLAG(err_flag),
    .FIRST_ERR_BEAT(first_err_beat)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Launch log (model) and DUT output history, indexed by edge number.
  logic [W-1:0] ld0 [NH], ld1 [NH], hd0 [NH], hd1 [NH];
  logic         lv  [NH];
  logic [31:0]  lt  [NH];

  // Model state: ph = -1 idle, 0 preamble, 1..BL burst beat, BL+1..BL+GL gap.
  int          ph;
  logic [1:0]  m_mode;
  int          n_cnt, n_walk;
  logic [30:0] m_lfsr;
  logic [31:0] m_beat, m_first;
  int          m_err;
  bit          m_flag;
  logic [W-1:0] e_d0, e_d1;
  bit          e_oe, e_dqs0, e_busy;

  bit flip_on = 0, perm_bad = 0, rnd_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    int  i, j, k;
    bit  mm;
    i = cyc % NH;
    j = (cyc + NH - L) % NH;
    if (rst) begin
      ph = -1; m_mode = 0; n_cnt = 0; n_walk = 0; m_lfsr = '1;
      m_beat = 0; m_err = 0; m_flag = 0; m_first = 0;
      for (int q = 0; q < L; q++) lv[(cyc + NH - q) % NH] = 1'b0;
      ld0[i] = '0; ld1[i] = '0;
      e_d0 = '0; e_d1 = '0; e_oe = 0; e_dqs0 = 0; e_busy = 0;
    end else begin
      mm = lv[j] && chk_en && ((rx_d0 !== ld0[j]) || (rx_d1 !== ld1[j]));
      if (clr) begin
        m_err = mm ? 1 : 0; m_flag = mm; m_first = mm ? lt[j] : 32'd0;
      end else if (mm) begin
        if (m_err < (1 << ECW) - 1) m_err++;
        if (!m_flag) begin m_flag = 1; m_first = lt[j]; end
      end
      if (!pll) begin
        ph = -1; n_cnt = 0; n_walk = 0; m_lfsr = '1;
      end else if (ph == -1) begin
        if (en) begin ph = 0; m_mode = mode; end
      end else if (ph == BL + GL) begin
        ph = en ? 0 : -1;
      end else begin
        ph++;
      end
      lv[i] = (ph >= 1 && ph <= BL);
      e_d0 = '0; e_d1 = '0;
      if (lv[i]) begin
        case (m_mode)
          2'd0: begin e_d0 = W'(n_cnt); e_d1 = ~W'(n_cnt); n_cnt++; end
          2'd1: begin
            k = (2 * n_walk) % W;
            e_d0 = W'(1) << k; e_d1 = W'(1) << (k + 1); n_walk++;
          end
          2'd2: begin
            e_d0 = m_lfsr[W-1:0]; e_d1 = ~m_lfsr[W-1:0];
            m_lfsr = {m_lfsr[29:0], m_lfsr[30] ^ m_lfsr[27]};
          end
          default: begin e_d0 = 16'h5555; e_d1 = 16'hAAAA; end
        endcase
        lt[i] = m_beat;
        m_beat++;
      end
      ld0[i] = e_d0; ld1[i] = e_d1;
      e_oe = (ph >= 0 && ph <= BL); e_dqs0 = lv[i]; e_busy = (ph != -1);
    end
  endtask

  task automatic step();
    int i, r;
    @(posedge clk);
    #1;
    model_edge();
    i = cyc % NH;
    hd0[i] = dq_d0; hd1[i] = dq_d1;
    check("dq_d0", dq_d0, e_d0);
    check("dq_d1", dq_d1, e_d1);
    check("dqs_d0", dqs_d0, e_dqs0);
    check("dqs_d1", dqs_d1, 0);
    check("oe", oe, e_oe);
    check("busy", busy, e_busy);
    check("beat_cnt", beat_cnt, m_beat);
    check("err_cnt", err_cnt, m_err);
    check("err_flag", err_flag, m_flag);
    check("first_err_beat", first_err_beat, m_first);
    cyc++;
    // Loopback: data arriving at the next edge is the launch from L edges before it.
    r = (cyc + NH - L) % NH;
    rx_d0 = hd0[r];
    rx_d1 = hd1[r];
    if (flip_on && lv[r] && lt[r] == 32'd5) rx_d1 = rx_d1 ^ 16'h0008;
    if (perm_bad) rx_d0 = ~rx_d0;
    if (rnd_bad && $urandom_range(29) == 0) rx_d0 = rx_d0 ^ (W'(1) << $urandom_range(W - 1));
  endtask

  task automatic do_reset();
    rst = 1; step(); step(); rst = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int oe_hi, g;
    bit seen;
    logic [31:0] b0;
    logic [W-1:0] first_prbs;
    for (int q = 0; q < NH; q++) begin
      lv[q] = 0; lt[q] = '0; ld0[q] = '0; ld1[q] = '0; hd0[q] = '0; hd1[q] = '0;
    end
    rst = 1; pll = 1; en = 0; mode = 0; chk_en = 0; clr = 0; rx_d0 = '0; rx_d1 = '0;
    step(); step(); step();
    rst = 0;
    step();

    // Counter mode, two full frames.
    mode = 0; en = 1; oe_hi = 0;
    for (int i = 0; i < 26; i++) begin
      step();
      oe_hi += int'(oe);
      if (i >= 1 && i <= BL) begin
        check("cnt_d0", dq_d0, 64'(i - 1));
        check("cnt_d1", dq_d1, 64'(16'hFFFF - 16'(i - 1)));
      end
    end
    check("oe_duty", 64'(oe_hi), 64'd18);
    check("beat16", beat_cnt, 64'd16);
    en = 0; step(); step();

    // Walking one, wrap into second burst.
    mode = 1; en = 1;
    step();
    for (int i = 0; i < BL; i++) begin
      step();
      check("walk_d0", dq_d0, 64'(1) << (2 * i));
      check("walk_d1", dq_d1, 64'(1) << (2 * i + 1));
    end
    repeat (GL + 1) step();
    step();
    check("walk_wrap", dq_d0, 64'h0001);
    en = 0;
    repeat (16) step();

    // PRBS loopback, 1000 beats.
    do_reset();
    mode = 2; chk_en = 1; en = 1; g = 0; seen = 0; first_prbs = '0;
    while (beat_cnt < 32'd1000 && g < 3000) begin
      step();
      if (dqs_d0 && !seen) begin seen = 1; first_prbs = dq_d0; end
      g++;
    end
    check("prbs_bound", 64'(beat_cnt >= 32'd1000), 64'd1);
    check("prbs_first", first_prbs, 64'hFFFF);
    en = 0;
    repeat (16) step();
    check("prbs_err_cnt", err_cnt, 64'd0);
    check("prbs_err_flag", err_flag, 64'd0);

    // Single flipped bit on beat 5, then clear.
    do_reset();
    mode = 2; chk_en = 1; flip_on = 1; en = 1;
    repeat (13) step();
    en = 0;
    repeat (4) step();
    flip_on = 0;
    check("flip_err_cnt", err_cnt, 64'd1);
    check("flip_err_flag", err_flag, 64'd1);
    check("flip_first_beat", first_err_beat, 64'd5);
    clr = 1; step(); clr = 0;
    check("clr_err_cnt", err_cnt, 64'd0);
    check("clr_err_flag", err_flag, 64'd0);
    check("clr_first_beat", first_err_beat, 64'd0);

    // Permanent mismatch saturates the 4-bit counter.
    mode = 3; perm_bad = 1; en = 1;
    repeat (40) step();
    check("sat_err_cnt", err_cnt, 64'd15);
    en = 0; perm_bad = 0;
    repeat (16) step();
    clr = 1; step(); clr = 0;

    // PLL loss during beat 3, then relock.
    chk_en = 0; mode = 0; en = 1;
    step();
    repeat (4) step();
    check("pll_beat3_d0", dq_d0, 64'd3);
    b0 = beat_cnt;
    pll = 0; step();
    check("pll_oe", oe, 64'd0);
    check("pll_busy", busy, 64'd0);
    pll = 1; step();
    step();
    check("relock_d0", dq_d0, 64'd0);
    check("relock_beats", beat_cnt, 64'(b0 + 32'd1));

    // Reset mid-burst.
    repeat (3) step();
    rst = 1; step();
    check("rst_oe", oe, 64'd0);
    check("rst_beats", beat_cnt, 64'd0);
    check("rst_d0", dq_d0, 64'd0);
    rst = 0; en = 0;
    step();

    // Randomized traffic with lock drops, clears and corrupted return data.
    rnd_bad = 1;
    for (int i = 0; i < 1500; i++) begin
      en     = ($urandom_range(9) != 0);
      mode   = 2'($urandom_range(3));
      chk_en = 1'($urandom_range(1));
      pll    = ($urandom_range(59) != 0);
      clr    = ($urandom_range(39) == 0);
      step();
    end
    rnd_bad = 0; pll = 1; en = 0; clr = 0;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
